// File: rtl/alu_result_buffer.sv
// alu_result_buffer
// Downstream stage of the ALU. Every cycle with alu_valid=1 is one push of
// {slt, zero, carry, data} into a small FIFO. The oldest entry is shown
// ahead on the res_* port for a slower consumer to drain. The block also
// reports the fill level and holds a sticky overflow flag.
//
// Handshake (output side): res_valid is high whenever the FIFO holds an
// entry, and res_* always show the head entry. A pop happens on a rising
// edge where res_valid=1 and res_ready=1. res_ready while empty is ignored.
// The input side has no back-pressure. A push into a full FIFO without a
// same-cycle pop is dropped and sets overflow.
//
// Priority at a clock edge: rst (async) > clr > push/pop.

module alu_result_buffer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [WIDTH-1:0] alu_data,
  input  logic             alu_carry,
  input  logic             alu_zero,
  input  logic             alu_slt,
  input  logic             alu_valid,
  output logic [WIDTH-1:0] res_data,
  output logic             res_carry,
  output logic             res_zero,
  output logic             res_slt,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             overflow
);

  // DEPTH is a power of two, so the pointers wrap naturally on overflow of
  // their own width.
  localparam int PTR_W = $clog2(DEPTH);
  localparam int ENT_W = WIDTH + 3;

  // Storage. It has no reset: the contents only matter while the count
  // covers them.
  logic [ENT_W-1:0] r_mem [DEPTH];

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_overflow;

  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic [ENT_W-1:0] w_wr_entry;
  logic [ENT_W-1:0] w_head;

  // Status flags and the handshake qualifiers for this cycle.
  always_comb begin
    w_full     = (r_count == CNT_W'(DEPTH));
    w_empty    = (r_count == '0);
    w_pop      = !w_empty && res_ready;
    // In the full case a same-cycle pop frees the slot the push reuses.
    w_push     = alu_valid && (!w_full || w_pop);
    w_drop     = alu_valid && w_full && !w_pop;
    w_wr_entry = {alu_slt, alu_zero, alu_carry, alu_data};
  end

  // Show-ahead head entry. It is forced to zero while empty, so a reset or
  // a flush clears the visible fields at once.
  always_comb begin
    w_head = '0;
    if (!w_empty) begin
      w_head = r_mem[r_rd_ptr];
    end
  end

  // Write the incoming entry into its slot. clr cancels the push.
  always_ff @(posedge clk) begin
    if (w_push && !clr) begin
      r_mem[r_wr_ptr] <= w_wr_entry;
    end
  end

  // Write pointer: advances on each accepted push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
    end else if (clr) begin
      r_wr_ptr <= '0;
    end else if (w_push) begin
      r_wr_ptr <= r_wr_ptr + PTR_W'(1);
    end
  end

  // Read pointer: advances on each pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= '0;
    end else if (clr) begin
      r_rd_ptr <= '0;
    end else if (w_pop) begin
      r_rd_ptr <= r_rd_ptr + PTR_W'(1);
    end
  end

  // Fill count: +1 on push alone, -1 on pop alone, otherwise unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky overflow: set when a push is dropped. Only rst or clr clear it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (clr) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end
  end

  // Output port mapping.
  always_comb begin
    res_data  = w_head[WIDTH-1:0];
    res_carry = w_head[WIDTH];
    res_zero  = w_head[WIDTH+1];
    res_slt   = w_head[WIDTH+2];
    res_valid = !w_empty;
    count     = r_count;
    full      = w_full;
    empty     = w_empty;
    overflow  = r_overflow;
  end

endmodule

// File: tb/tb_alu_result_buffer.sv
// Testbench for alu_result_buffer. A queue-based reference model is
// compared against every output after every clock edge. The bench runs
// directed scenarios first, then randomized traffic.

module tb_alu_result_buffer;

  localparam int W   = 8;
  localparam int D   = 4;
  localparam int CW  = $clog2(D) + 1;
  localparam int EW  = W + 3;

  logic          clk;
  logic          rst;
  logic          clr;
  logic [W-1:0]  alu_data;
  logic          alu_carry;
  logic          alu_zero;
  logic          alu_slt;
  logic          alu_valid;
  logic [W-1:0]  res_data;
  logic          res_carry;
  logic          res_zero;
  logic          res_slt;
  logic          res_valid;
  logic          res_ready;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          overflow;

  alu_result_buffer #(.WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .alu_data  (alu_data),
    .alu_carry (alu_carry),
    .alu_zero  (alu_zero),
    .alu_slt   (alu_slt),
    .alu_valid (alu_valid),
    .res_data  (res_data),
    .res_carry (res_carry),
    .res_zero  (res_zero),
    .res_slt   (res_slt),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  bit            exp_ovf;
  int            n_cmp;
  int            n_err;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    logic [EW-1:0] head;
    int            sz;
    sz   = exp_q.size();
    head = (sz > 0) ? exp_q[0] : '0;
    check({tag, ".count"},     32'(count),     32'(sz));
    check({tag, ".empty"},     32'(empty),     32'(sz == 0));
    check({tag, ".full"},      32'(full),      32'(sz == D));
    check({tag, ".res_valid"}, 32'(res_valid), 32'(sz != 0));
    check({tag, ".overflow"},  32'(overflow),  32'(exp_ovf));
    check({tag, ".res_entry"},
          32'({res_slt, res_zero, res_carry, res_data}), 32'(head));
  endtask

  // Reference model: one clock edge of FIFO behaviour, taken from the
  // current inputs.
  task automatic model_edge();
    bit was_full;
    bit do_pop;
    if (clr) begin
      exp_q.delete();
      exp_ovf = 0;
      return;
    end
    was_full = (exp_q.size() == D);
    do_pop   = (exp_q.size() > 0) && res_ready;
    if (do_pop) void'(exp_q.pop_front());
    if (alu_valid) begin
      if (!was_full || do_pop)
        exp_q.push_back({alu_slt, alu_zero, alu_carry, alu_data});
      else
        exp_ovf = 1;
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic drive(input string tag, input bit v, input logic [W-1:0] d,
                       input bit c, input bit z, input bit s,
                       input bit rdy, input bit cl);
    alu_valid = v;
    alu_data  = d;
    alu_carry = c;
    alu_zero  = z;
    alu_slt   = s;
    res_ready = rdy;
    clr       = cl;
    step(tag);
  endtask

  task automatic push(input string tag, input logic [W-1:0] d);
    drive(tag, 1, d, 0, (d == 0), 0, 0, 0);
  endtask

  task automatic pop(input string tag);
    drive(tag, 0, 8'h00, 0, 0, 0, 1, 0);
  endtask

  task automatic idle(input string tag);
    drive(tag, 0, 8'h00, 0, 0, 0, 0, 0);
  endtask

  // Async reset pulse between edges. Outputs are checked before any edge.
  task automatic async_reset(input string tag);
    #3;
    rst = 1'b1;
    exp_q.delete();
    exp_ovf = 0;
    #1;
    check_all(tag);
    #1;
    rst = 1'b0;
  endtask

  logic [W-1:0] vals[4];

  initial begin
    n_cmp = 0;
    n_err = 0;
    exp_ovf = 0;
    rst = 1'b1;
    clr = 0; alu_valid = 0; alu_data = 0; alu_carry = 0;
    alu_zero = 0; alu_slt = 0; res_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b0;

    // Idle: count stays zero.
    for (int i = 0; i < 5; i++) idle("idle");

    // Mid-operation async reset discards entries immediately.
    push("pre_rst", 8'h11);
    push("pre_rst", 8'h22);
    async_reset("async_rst");
    idle("post_rst");

    // Single capture then pop.
    drive("single", 1, 8'd90, 0, 0, 1, 0, 0);
    idle("single_hold");
    pop("single_pop");

    // Ordering and wrap-around, three rounds.
    vals[0] = 8'd40; vals[1] = 8'd0; vals[2] = 8'd30; vals[3] = 8'd255;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 4; i++) push("order_push", vals[i]);
      for (int i = 0; i < 4; i++) pop("order_pop");
    end

    // Overflow: push 1..5 into a depth-4 FIFO, drain, then clr.
    for (int i = 1; i <= 5; i++) push("ovf_push", 8'(i));
    for (int i = 0; i < 4; i++) pop("ovf_drain");
    idle("ovf_sticky");
    drive("ovf_clr", 0, 8'h00, 0, 0, 0, 0, 1);

    // Full with simultaneous push and pop.
    push("fpp_fill", 8'd10);
    push("fpp_fill", 8'd20);
    push("fpp_fill", 8'd30);
    push("fpp_fill", 8'd40);
    drive("fpp_both", 1, 8'd50, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) pop("fpp_drain");

    // clr takes priority over push and pop.
    push("clrp_fill", 8'd7);
    push("clrp_fill", 8'd8);
    drive("clrp", 1, 8'd9, 1, 0, 1, 1, 1);
    idle("clrp_after");

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      drive("rand",
            ($urandom_range(0, 99) < 55),
            8'($urandom),
            1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 99) < 45),
            ($urandom_range(0, 63) == 0));
      if ($urandom_range(0, 299) == 0) async_reset("rand_rst");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
